fp32_sum_capture_fifo: RTL

Downstream stage of the combinational single-precision adder. It takes the adder's 32-bit sum under a valid/ready handshake, classifies it (zero, subnormal, infinity, NaN, sign), and buffers the word with its class in a small FIFO for the consumer. It also keeps sticky infinity and NaN flags for status readout.

---
 rtl/fp32_sum_capture_fifo.sv | 76 +++++++
 1 files changed

// File: rtl/fp32_sum_capture_fifo.sv
// fp32_sum_capture_fifo: classifies fp32 adder results and buffers word+class in a
// first-word-fall-through FIFO, with sticky infinity/NaN status flags.
module fp32_sum_capture_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_sum,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_sum,
   output logic [4:0]                 out_class,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       clr_flags,
   output logic                       inf_seen,
   output logic                       nan_seen
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [36:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          inf_q, inf_d, nan_q, nan_d;
   logic          push, pop;
   logic [7:0]    e;
   logic [22:0]   m;
   logic [4:0]    cls;

   assign e   = in_sum[30:23];
   assign m   = in_sum[22:0];
   assign cls = {in_sum[31], e == 8'hFF && m != '0, e == 8'hFF && m == '0,
                 e == '0 && m != '0, e == '0 && m == '0};

   assign in_ready  = count_q != FULL;
   assign out_valid = count_q != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      inf_d   = (push && cls[2]) || (inf_q && !clr_flags);
      nan_d   = (push && cls[3]) || (nan_q && !clr_flags);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         inf_q   <= 1'b0;
         nan_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         inf_q   <= inf_d;
         nan_q   <= nan_d;
      end
   end

   // Storage needs no reset: the output is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {cls, in_sum};
   end

   assign out_sum   = out_valid ? mem_q[rptr_q][31:0] : '0;
   assign out_class = out_valid ? mem_q[rptr_q][36:32] : '0;
   assign count     = count_q;
   assign inf_seen  = inf_q;
   assign nan_seen  = nan_q;
endmodule
